// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2,
    FAULT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the arbiter's CPU-side and RAM-side signals, with arbiter and bench views.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      ihit;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dhit;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      fault;

  modport arbiter (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, fault
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, fault
  );

endinterface

// File: rtl/memory_arbiter_access_timer.sv
// Saturating wait counter for one RAM transaction; flags when the next wait reaches TIMEOUT.
module access_timer #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] count_r;

  // Wait-cycle counter: cleared per transaction, stops at LIMIT instead of wrapping
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (count && (count_r != LIMIT)) begin
      count_r <= count_r + ONE;
    end
  end

  assign expired = count && (count_r >= LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory; data has priority,
// one latched transaction at a time, hung or failed RAM accesses trap into a sticky fault.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      ihit,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dhit,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      fault
);

  arb_state_t state_r;
  arb_state_t next_s;
  word_t      addr_r;
  word_t      store_r;
  word_t      iload_r;
  word_t      dload_r;
  logic       ren_r;
  logic       wen_r;
  logic       dreq_s;
  logic       serving_s;
  logic       timer_clear_s;
  logic       timer_count_s;
  logic       expired_s;
  logic       ihit_s;
  logic       dhit_s;

  assign dreq_s    = dREN | dWEN;
  assign serving_s = (state_r == DSERV) || (state_r == ISERV);

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and timer control
  always_comb begin
    next_s        = state_r;
    timer_clear_s = 1'b0;
    timer_count_s = 1'b0;
    case (state_r)
      IDLE: begin
        timer_clear_s = 1'b1;
        if (dreq_s) begin
          next_s = DSERV;
        end else if (iREN) begin
          next_s = ISERV;
        end else begin
          next_s = IDLE;
        end
      end
      DSERV, ISERV: begin
        case (ramstate)
          ACCESS:  next_s = IDLE;
          ERROR:   next_s = FAULT;
          default: begin
            timer_count_s = 1'b1;
            if (expired_s) begin
              next_s = FAULT;
            end else begin
              next_s = state_r;
            end
          end
        endcase
      end
      FAULT:   next_s = FAULT;
      default: next_s = FAULT;
    endcase
  end

  // Completion strobes; a requester that dropped its enable gets no hit
  always_comb begin
    ihit_s = 1'b0;
    dhit_s = 1'b0;
    if (ramstate == ACCESS) begin
      ihit_s = (state_r == ISERV) && iREN;
      dhit_s = (state_r == DSERV) && dreq_s;
    end else begin
      ihit_s = 1'b0;
      dhit_s = 1'b0;
    end
  end

  // Request latch, loaded only in IDLE so live inputs cannot disturb the RAM bus
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      addr_r  <= 32'h0000_0000;
      store_r <= 32'h0000_0000;
      ren_r   <= 1'b0;
      wen_r   <= 1'b0;
    end else if ((state_r == IDLE) && dreq_s) begin
      addr_r  <= daddr;
      store_r <= dstore;
      wen_r   <= dWEN;
      ren_r   <= ~dWEN;
    end else if ((state_r == IDLE) && iREN) begin
      addr_r  <= iaddr;
      store_r <= 32'h0000_0000;
      wen_r   <= 1'b0;
      ren_r   <= 1'b1;
    end
  end

  // Last delivered load values
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      iload_r <= 32'h0000_0000;
      dload_r <= 32'h0000_0000;
    end else begin
      if (ihit_s) begin
        iload_r <= ramload;
      end
      if (dhit_s) begin
        dload_r <= ramload;
      end
    end
  end

  access_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (timer_clear_s),
    .count   (timer_count_s),
    .expired (expired_s)
  );

  assign ramREN   = serving_s & ren_r;
  assign ramWEN   = serving_s & wen_r;
  assign ramaddr  = addr_r;
  assign ramstore = store_r;
  assign ihit     = ihit_s;
  assign dhit     = dhit_s;
  assign iload    = ihit_s ? ramload : iload_r;
  assign dload    = dhit_s ? ramload : dload_r;
  assign fault    = (state_r == FAULT);

endmodule
